abro_seq_ctrl: RTL and testbench
================================

# abro_seq_ctrl

Sequencing controller for the ABRO state machine. It resets the ABRO instance, drives its A/B inputs in a programmed order with a programmed gap, and waits a bounded time for O. It then grades the run against the outcome the order should produce and keeps saturating pass/fail counts. It sits between a host/register block and one ABRO instance, owning that instance's reset and inputs.

## Interface
- GAP_W, 8, width of cfg_gap
- TMO_W, 8, width of cfg_timeout
- CNT_W, 16, width of pass/fail counters
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset; one clock domain
- start  in  1  run request; sampled only in IDLE, ignored otherwise
- abort  in  1  cancel current run; highest priority in every non-IDLE state
- cfg_order  in  2  00 A→B, 01 B→A, 10 A+B together, 11 A only
- cfg_gap  in  GAP_W  extra cycles between first and second input
- cfg_timeout  in  TMO_W  max WAIT cycles for O; 0 treated as 1
- abro_o  in  1  O from ABRO instance
- abro_rst_n  out  1  active-low reset to ABRO instance
- abro_a, abro_b  out  1 each  A/B to ABRO instance
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of a graded run
- pass  out  1  grade of last run, valid from done, held until next done
- timed_out  out  1  last run ended by timeout, held like pass
- pass_cnt, fail_cnt  out  CNT_W each  saturating run counters
- ctrl_state  out  3  current FSM state encoding, debug

## Operation
- States: IDLE, RST, ARM1, ARM2, WAIT, DONE, ABORT.
- IDLE: abro_rst_n=1, a=b=0. start=1 → latch cfg_order/gap/timeout, → RST.
- RST: abro_rst_n=0, a=b=0 for exactly 2 cycles, → ARM1.
- ARM1: assert first input (A for 00/11, B for 01, both for 10). Hold for cfg_gap+1 cycles. Then → ARM2 for 00/01, → WAIT for 10/11.
- ARM2: first input stays high, second asserted; 1 cycle, → WAIT.
- WAIT: a/b keep their values. abro_o=1 → DONE with o_seen=1. Otherwise, after latched timeout cycles → DONE with o_seen=0 and timed_out=1.
- Expected O: 1 for orders 00/01/10, 0 for 11. pass = (o_seen == expected).
- DONE: 1 cycle. a=b=0, done=1, pass/timed_out updated, pass_cnt or fail_cnt +1 (saturate at all-ones, no wrap). → IDLE.
- ABORT: entered from any non-IDLE state on abort=1. 1 cycle, abro_rst_n=0, a=b=0, no done, counters/pass unchanged. → IDLE.
- Simultaneous events: abort beats abro_o and timeout. abro_o in the same cycle as the timeout expiry counts as seen (pass path). start during DONE/ABORT is ignored.
- Config inputs change freely while busy; only latched values are used.

## Timing
- Reset (reset_n low, async): state=IDLE, abro_rst_n=0, a=b=0, busy=0, done=0, pass=0, timed_out=0, counters=0. abro_rst_n goes to 1 at the first clk edge after reset release.
- All outputs are registered and change on the edge that enters the state.
- start sampled at edge N: abro_rst_n low for cycles N..N+1, first input high from edge N+2, second input from edge N+3+cfg_gap.
- WAIT samples abro_o every cycle, starting at the first WAIT cycle. Worst-case run length is 2 + (cfg_gap+1) + 1 + timeout + 1 cycles.
- done is high exactly one cycle. Counters update on the same edge that asserts done.
- reset_n asserted mid-run: immediate return to the reset values above; no done.

## Structure
- Package abro_pkg: state enum, order enum (ORD_AB, ORD_BA, ORD_SIM, ORD_A), RST_CYCLES=2, and a function returning expected O per order.
- Sub-module abro_sat_cnt (CNT_W, inc, saturating, async active-low reset), instantiated twice for pass_cnt and fail_cnt.
- One shared down-counter in the top level, reused for the RST, gap and timeout intervals.

## Test plan
- Order 00, gap 0, timeout 8, ABRO model raises O 1 cycle after B → A at N+2, B at N+3, done, pass=1, pass_cnt=1.
- Order 01, gap 3, ABRO gives no O → timed_out=1 after 8 WAIT cycles, pass=0, fail_cnt=1.
- Order 11, timeout 4, no O → timed_out=1, pass=1; a model that wrongly raises O instead → pass=0.
- abort during ARM2 and again during WAIT → 1 cycle with abro_rst_n=0, no done, counters unchanged, busy low next cycle.
- Force pass_cnt to all-ones (CNT_W=2, 4 passing runs) → stays 3, no wrap; start while busy is ignored.
- reset_n pulsed mid-WAIT (async, between edges) → outputs at reset values immediately; a new start works normally.

Source files
------------

// File: rtl/abro_pkg.sv
// Shared types and helpers for the ABRO sequencing controller.
package abro_pkg;

  // Controller states; the encoding is exported on ctrl_state for debug.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_ARM1  = 3'd2,
    ST_ARM2  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ABORT = 3'd6
  } state_e;

  // Order in which A and B are presented to the ABRO instance.
  typedef enum logic [1:0] {
    ORD_AB  = 2'b00,
    ORD_BA  = 2'b01,
    ORD_SIM = 2'b10,
    ORD_A   = 2'b11
  } order_e;

  // Number of cycles the ABRO instance is held in reset before arming.
  localparam int RST_CYCLES = 2;

  // O should only appear when both A and B have been presented.
  function automatic logic expected_o(order_e ord);
    return (ord != ORD_A);
  endfunction

  // First input pattern {a, b} asserted in ARM1.
  function automatic logic [1:0] first_ab(order_e ord);
    logic [1:0] ab;
    case (ord)
      ORD_BA:  ab = 2'b01;
      ORD_SIM: ab = 2'b11;
      default: ab = 2'b10;
    endcase
    return ab;
  endfunction

  // Sequential orders need an ARM2 step to raise the second input.
  function automatic logic has_second(order_e ord);
    return (ord == ORD_AB) || (ord == ORD_BA);
  endfunction

endpackage

// File: rtl/abro_sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module abro_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: hold once all-ones is reached so the value never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/abro_seq_ctrl.sv
// Sequencing controller: resets one ABRO instance, presents A/B in the
// programmed order and gap, waits a bounded time for O and grades the run.
module abro_seq_ctrl
  import abro_pkg::*;
#(
  parameter int GAP_W = 8,
  parameter int TMO_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       cfg_order,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic             abro_o,
  output logic             abro_rst_n,
  output logic             abro_a,
  output logic             abro_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timed_out,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [2:0]       ctrl_state
);

  // One down-counter serves the reset hold, the gap and the timeout.
  localparam int CW = (GAP_W > TMO_W) ? GAP_W : TMO_W;

  state_e           state_q;
  order_e           order_q;
  logic [GAP_W-1:0] gap_q;
  logic [TMO_W-1:0] tmo_load_q;
  logic [CW-1:0]    cnt_q;
  logic             abro_rst_n_q;
  logic             a_q;
  logic             b_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             timed_out_q;

  // WAIT ends this cycle when O is seen or the timeout runs out; abort wins.
  logic wait_end;
  logic run_pass;
  assign wait_end = (state_q == ST_WAIT) && !abort && (abro_o || (cnt_q == '0));
  assign run_pass = (abro_o == expected_o(order_q));

  // Main FSM with registered outputs set on the edge that enters each state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      order_q      <= ORD_AB;
      gap_q        <= '0;
      tmo_load_q   <= '0;
      cnt_q        <= '0;
      abro_rst_n_q <= 1'b0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timed_out_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state_q != ST_IDLE) && abort) begin
        state_q      <= ST_ABORT;
        abro_rst_n_q <= 1'b0;
        a_q          <= 1'b0;
        b_q          <= 1'b0;
        busy_q       <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              order_q      <= order_e'(cfg_order);
              gap_q        <= cfg_gap;
              // A zero timeout behaves like one WAIT cycle.
              tmo_load_q   <= (cfg_timeout == '0) ? '0 : cfg_timeout - TMO_W'(1);
              cnt_q        <= CW'(RST_CYCLES - 1);
              state_q      <= ST_RST;
              abro_rst_n_q <= 1'b0;
              busy_q       <= 1'b1;
            end else begin
              abro_rst_n_q <= 1'b1;
              busy_q       <= 1'b0;
            end
            a_q <= 1'b0;
            b_q <= 1'b0;
          end
          ST_RST: begin
            if (cnt_q == '0) begin
              state_q      <= ST_ARM1;
              abro_rst_n_q <= 1'b1;
              {a_q, b_q}   <= first_ab(order_q);
              cnt_q        <= CW'(gap_q);
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          ST_ARM1: begin
            if (cnt_q == '0) begin
              if (has_second(order_q)) begin
                state_q <= ST_ARM2;
                a_q     <= 1'b1;
                b_q     <= 1'b1;
              end else begin
                state_q <= ST_WAIT;
                cnt_q   <= CW'(tmo_load_q);
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          ST_ARM2: begin
            state_q <= ST_WAIT;
            cnt_q   <= CW'(tmo_load_q);
          end
          ST_WAIT: begin
            if (wait_end) begin
              state_q     <= ST_DONE;
              a_q         <= 1'b0;
              b_q         <= 1'b0;
              done_q      <= 1'b1;
              pass_q      <= run_pass;
              timed_out_q <= !abro_o;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          ST_ABORT: begin
            state_q      <= ST_IDLE;
            abro_rst_n_q <= 1'b1;
            busy_q       <= 1'b0;
          end
          default: begin
            state_q      <= ST_IDLE;
            abro_rst_n_q <= 1'b1;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
          end
        endcase
      end
    end
  end

  abro_sat_cnt #(.CNT_W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (wait_end && run_pass),
    .cnt   (pass_cnt)
  );

  abro_sat_cnt #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (wait_end && !run_pass),
    .cnt   (fail_cnt)
  );

  assign abro_rst_n = abro_rst_n_q;
  assign abro_a     = a_q;
  assign abro_b     = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timed_out  = timed_out_q;
  assign ctrl_state = state_q;

endmodule

// File: tb/tb_abro_seq_ctrl.sv
// Directed bench for abro_seq_ctrl with a small behavioural ABRO model.
module tb_abro_seq_ctrl;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic             abort;
  logic [1:0]       cfg_order;
  logic [7:0]       cfg_gap;
  logic [7:0]       cfg_timeout;
  logic             abro_o;
  logic             abro_rst_n;
  logic             abro_a;
  logic             abro_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timed_out;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [2:0]       ctrl_state;

  int n_cmp = 0;
  int n_bad = 0;

  // 0: real ABRO, 1: never raises O, 2: faulty, raises O on A alone
  int   model_mode = 0;
  logic seen_a = 1'b0;
  logic seen_b = 1'b0;
  logic o_r    = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!abro_rst_n) begin
      seen_a <= 1'b0;
      seen_b <= 1'b0;
      o_r    <= 1'b0;
    end else begin
      seen_a <= seen_a | abro_a;
      seen_b <= seen_b | abro_b;
      case (model_mode)
        0:       o_r <= (seen_a | abro_a) & (seen_b | abro_b);
        1:       o_r <= 1'b0;
        default: o_r <= seen_a | abro_a;
      endcase
    end
  end
  assign abro_o = o_r;

  abro_seq_ctrl #(.GAP_W(8), .TMO_W(8), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .cfg_order   (cfg_order),
    .cfg_gap     (cfg_gap),
    .cfg_timeout (cfg_timeout),
    .abro_o      (abro_o),
    .abro_rst_n  (abro_rst_n),
    .abro_a      (abro_a),
    .abro_b      (abro_b),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .timed_out   (timed_out),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt),
    .ctrl_state  (ctrl_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Issue start (edge N) and return at the negedge just after edge N (index 0).
  task automatic kick(input logic [1:0] ord, input logic [7:0] gap, input logic [7:0] tmo);
    @(negedge clk);
    cfg_order   = ord;
    cfg_gap     = gap;
    cfg_timeout = tmo;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    // scramble config to show only latched values matter
    cfg_order   = ~ord;
    cfg_gap     = 8'hff;
    cfg_timeout = 8'h01;
  endtask

  // Full run: records reset history, first/second inputs, done index and
  // the {busy,done} pair on the cycle after done.
  task automatic do_run(input logic [1:0] ord, input logic [7:0] gap, input logic [7:0] tmo,
                        input int stray_idx, output int done_idx, output logic [2:0] rst_hist,
                        output logic [1:0] ab_first, output logic [1:0] ab_second,
                        output logic [1:0] post);
    done_idx  = -1;
    rst_hist  = 3'b000;
    ab_first  = 2'b00;
    ab_second = 2'b00;
    kick(ord, gap, tmo);
    for (int idx = 0; idx < 600; idx++) begin
      if (idx < 3) rst_hist[2-idx] = abro_rst_n;
      if (idx == 2) ab_first = {abro_a, abro_b};
      if (idx == 3 + int'(gap)) ab_second = {abro_a, abro_b};
      start = 1'b0;
      if (idx == stray_idx) start = 1'b1;
      if (done === 1'b1) begin
        done_idx = idx;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    post = {busy, done};
  endtask

  // Start a run, advance to index idx, pulse abort, snapshot two cycles.
  task automatic do_abort(input logic [1:0] ord, input logic [7:0] gap, input logic [7:0] tmo,
                          input int idx, output logic [2:0] pre_state,
                          output logic [7:0] snap1, output logic [7:0] snap2);
    kick(ord, gap, tmo);
    repeat (idx) @(negedge clk);
    pre_state = ctrl_state;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    snap1 = {abro_rst_n, abro_a, abro_b, busy, done, ctrl_state};
    @(negedge clk);
    snap2 = {abro_rst_n, abro_a, abro_b, busy, done, ctrl_state};
  endtask

  int         di;
  logic [2:0] rh;
  logic [1:0] af;
  logic [1:0] as2;
  logic [1:0] post;
  logic [2:0] pre;
  logic [7:0] s1;
  logic [7:0] s2;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_order = 2'b00; cfg_gap = 8'd0; cfg_timeout = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset_abro_rst_n", abro_rst_n, 0);
    chk("reset_ab", {abro_a, abro_b}, 0);
    chk("reset_busy_done", {busy, done}, 0);
    chk("reset_pass_to", {pass, timed_out}, 0);
    chk("reset_counts", {pass_cnt, fail_cnt}, 0);
    chk("reset_state", ctrl_state, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("release_abro_rst_n", abro_rst_n, 1);

    // order 00, gap 0, timeout 8, true ABRO
    model_mode = 0;
    do_run(2'b00, 8'd0, 8'd8, -1, di, rh, af, as2, post);
    chk("t1_done_idx", di, 5);
    chk("t1_rst_hist", rh, 3'b001);
    chk("t1_first_ab", af, 2'b10);
    chk("t1_second_ab", as2, 2'b11);
    chk("t1_post", post, 2'b00);
    chk("t1_pass_to", {pass, timed_out}, 2'b10);
    chk("t1_counts", {pass_cnt, fail_cnt}, {2'd1, 2'd0});

    // order 01, gap 3, timeout 8, silent ABRO -> timeout fail
    model_mode = 1;
    do_run(2'b01, 8'd3, 8'd8, -1, di, rh, af, as2, post);
    chk("t2_done_idx", di, 15);
    chk("t2_first_ab", af, 2'b01);
    chk("t2_second_ab", as2, 2'b11);
    chk("t2_pass_to", {pass, timed_out}, 2'b01);
    chk("t2_counts", {pass_cnt, fail_cnt}, {2'd1, 2'd1});

    // order 11, timeout 4, silent ABRO -> timeout but pass
    do_run(2'b11, 8'd0, 8'd4, -1, di, rh, af, as2, post);
    chk("t3_done_idx", di, 7);
    chk("t3_first_ab", af, 2'b10);
    chk("t3_pass_to", {pass, timed_out}, 2'b11);
    chk("t3_counts", {pass_cnt, fail_cnt}, {2'd2, 2'd1});

    // order 11 with faulty ABRO raising O -> fail, no timeout
    model_mode = 2;
    do_run(2'b11, 8'd0, 8'd4, -1, di, rh, af, as2, post);
    chk("t3b_done_idx", di, 4);
    chk("t3b_pass_to", {pass, timed_out}, 2'b00);
    chk("t3b_counts", {pass_cnt, fail_cnt}, {2'd2, 2'd2});

    // timeout 0 acts as 1 WAIT cycle
    model_mode = 1;
    do_run(2'b11, 8'd0, 8'd0, -1, di, rh, af, as2, post);
    chk("t4_done_idx", di, 4);
    chk("t4_pass_to", {pass, timed_out}, 2'b11);
    chk("t4_counts", {pass_cnt, fail_cnt}, {2'd3, 2'd2});

    // two more passing runs: pass_cnt saturates, stray start ignored
    model_mode = 0;
    for (int r = 0; r < 2; r++) begin
      do_run(2'b10, 8'd1, 8'd8, 3, di, rh, af, as2, post);
      chk("sat_done_idx", di, 5);
      chk("sat_first_ab", af, 2'b11);
      chk("sat_post", post, 2'b00);
      chk("sat_counts", {pass_cnt, fail_cnt}, {2'd3, 2'd2});
    end

    // abort during ARM2
    do_abort(2'b00, 8'd2, 8'd8, 5, pre, s1, s2);
    chk("ab_arm2_pre", pre, 3);
    chk("ab_arm2_s1", s1, 8'h16);
    chk("ab_arm2_s2", s2, 8'h80);
    chk("ab_arm2_counts", {pass_cnt, fail_cnt}, {2'd3, 2'd2});
    chk("ab_arm2_pass_to", {pass, timed_out}, 2'b10);

    // abort during WAIT
    model_mode = 1;
    do_abort(2'b11, 8'd0, 8'd8, 4, pre, s1, s2);
    chk("ab_wait_pre", pre, 4);
    chk("ab_wait_s1", s1, 8'h16);
    chk("ab_wait_s2", s2, 8'h80);
    chk("ab_wait_counts", {pass_cnt, fail_cnt}, {2'd3, 2'd2});

    // async reset mid-WAIT
    kick(2'b01, 8'd0, 8'd8);
    repeat (6) @(negedge clk);
    chk("mr_pre_state", ctrl_state, 4);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_abro_rst_n", abro_rst_n, 0);
    chk("mr_ab_busy_done", {abro_a, abro_b, busy, done}, 0);
    chk("mr_pass_to", {pass, timed_out}, 0);
    chk("mr_counts", {pass_cnt, fail_cnt}, 0);
    chk("mr_state", ctrl_state, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mr_release", {abro_rst_n, busy}, 2'b10);

    // a fresh run after reset works normally
    model_mode = 0;
    do_run(2'b00, 8'd0, 8'd8, -1, di, rh, af, as2, post);
    chk("t5_done_idx", di, 5);
    chk("t5_pass_to", {pass, timed_out}, 2'b10);
    chk("t5_counts", {pass_cnt, fail_cnt}, {2'd1, 2'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
